// File: rtl/costas_lock_ctrl.sv
// Costas loop lock sequencer: windowed I/Q magnitude test drives an
// acquire/settle/track FSM that picks loop gain, polarity and lock status.
//
// state   | meaning
// IDLE    | sequencer disabled, gain off
// PULL_IN | wide-gain acquisition, counting consecutive passing windows
// SETTLE  | medium gain, must see SETTLE_WINS passing windows in a row
// TRACK   | narrow gain, locked, polarity follows each window
module costas_lock_ctrl #(
  parameter int MIDPOINT    = 5000,
  parameter int WIN_LOG2    = 6,
  parameter int LOCK_WINS   = 4,
  parameter int SETTLE_WINS = 8,
  parameter int LOSS_WINS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [13:0] i_in,
  input  logic [13:0] q_in,
  output logic [1:0]  gain_sel,
  output logic        invert,
  output logic        locked,
  output logic        loss_pulse,
  output logic [1:0]  state_dbg
);

  localparam int SUM_W = 14 + WIN_LOG2;
  localparam int NEG_W = WIN_LOG2 + 1;
  localparam int CNT_W = 8;
  localparam logic [13:0]      MID         = 14'(MIDPOINT);
  localparam logic [NEG_W-1:0] NEG_HALF    = NEG_W'(1 << (WIN_LOG2 - 1));
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WINS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_WINS - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_WINS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULL_IN = 2'd1,
    SETTLE  = 2'd2,
    TRACK   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [13:0]       abs_i, abs_q;
  logic              i_neg;
  logic [WIN_LOG2-1:0] samp_cnt;
  logic [SUM_W-1:0]  sum_i, sum_q, sum_i_nxt, sum_q_nxt;
  logic [SUM_W-1:0]  win_sum_i, win_sum_q;
  logic [NEG_W-1:0]  neg_cnt, neg_cnt_nxt, win_neg;
  logic              win_end, dec_valid;
  logic              win_pass, win_is_neg;

  logic [CNT_W-1:0]  good_cnt, good_nxt;
  logic [CNT_W-1:0]  settle_cnt, settle_nxt;
  logic [CNT_W-1:0]  bad_cnt, bad_nxt;
  logic              invert_nxt, loss_nxt;

  // Magnitude about the offset-binary zero; always fits 14 bits.
  always_comb begin
    abs_i = (i_in >= MID) ? (i_in - MID) : (MID - i_in);
    abs_q = (q_in >= MID) ? (q_in - MID) : (MID - q_in);
    i_neg = (i_in < MID);
    sum_i_nxt   = sum_i + SUM_W'(abs_i);
    sum_q_nxt   = sum_q + SUM_W'(abs_q);
    neg_cnt_nxt = neg_cnt + {{WIN_LOG2{1'b0}}, i_neg};
    win_end     = sample_valid && (samp_cnt == '1);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      samp_cnt  <= '0;
      sum_i     <= '0;
      sum_q     <= '0;
      neg_cnt   <= '0;
      win_sum_i <= '0;
      win_sum_q <= '0;
      win_neg   <= '0;
      dec_valid <= 1'b0;
    end else begin
      dec_valid <= win_end;
      if (sample_valid) begin
        samp_cnt <= samp_cnt + 1'b1;
        if (win_end) begin
          win_sum_i <= sum_i_nxt;
          win_sum_q <= sum_q_nxt;
          win_neg   <= neg_cnt_nxt;
          sum_i     <= '0;
          sum_q     <= '0;
          neg_cnt   <= '0;
        end else begin
          sum_i   <= sum_i_nxt;
          sum_q   <= sum_q_nxt;
          neg_cnt <= neg_cnt_nxt;
        end
      end
    end
  end

  // One extra bit so 2*sumQ cannot wrap.
  always_comb begin
    win_pass   = {1'b0, win_sum_i} >= {win_sum_q, 1'b0};
    win_is_neg = win_neg > NEG_HALF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      good_cnt   <= '0;
      settle_cnt <= '0;
      bad_cnt    <= '0;
      invert     <= 1'b0;
      loss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      settle_cnt <= settle_nxt;
      bad_cnt    <= bad_nxt;
      invert     <= invert_nxt;
      loss_pulse <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    good_nxt   = good_cnt;
    settle_nxt = settle_cnt;
    bad_nxt    = bad_cnt;
    invert_nxt = invert;
    loss_nxt   = 1'b0;
    if (!enable) begin
      state_nxt  = IDLE;
      good_nxt   = '0;
      settle_nxt = '0;
      bad_nxt    = '0;
      invert_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = PULL_IN;
          good_nxt   = '0;
          settle_nxt = '0;
          bad_nxt    = '0;
          invert_nxt = 1'b0;
        end
        PULL_IN: begin
          if (dec_valid) begin
            if (!win_pass) begin
              good_nxt = '0;
            end else if (good_cnt == LOCK_LAST) begin
              state_nxt  = SETTLE;
              good_nxt   = '0;
              settle_nxt = '0;
            end else begin
              good_nxt = good_cnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (dec_valid) begin
            if (!win_pass) begin
              state_nxt  = PULL_IN;
              good_nxt   = '0;
              settle_nxt = '0;
            end else if (settle_cnt == SETTLE_LAST) begin
              state_nxt  = TRACK;
              settle_nxt = '0;
              bad_nxt    = '0;
              invert_nxt = win_is_neg;
            end else begin
              settle_nxt = settle_cnt + 1'b1;
            end
          end
        end
        TRACK: begin
          if (dec_valid) begin
            invert_nxt = win_is_neg;
            if (win_pass) begin
              bad_nxt = '0;
            end else if (bad_cnt == LOSS_LAST) begin
              state_nxt = PULL_IN;
              loss_nxt  = 1'b1;
              bad_nxt   = '0;
              good_nxt  = '0;
            end else begin
              bad_nxt = bad_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    state_dbg = state;
    locked    = (state == TRACK);
    case (state)
      PULL_IN: gain_sel = 2'd3;
      SETTLE:  gain_sel = 2'd2;
      TRACK:   gain_sel = 2'd1;
      default: gain_sel = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Directed bench for costas_lock_ctrl: lock, polarity, loss, boundary,
// stretched windows, enable drop and reset.
module tb_costas_lock_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sample_valid;
  logic [13:0] i_in, q_in;
  logic [1:0]  gain_sel;
  logic        invert, locked, loss_pulse;
  logic [1:0]  state_dbg;

  int compared   = 0;
  int mismatched = 0;

  costas_lock_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .i_in(i_in), .q_in(q_in), .gain_sel(gain_sel), .invert(invert),
    .locked(locked), .loss_pulse(loss_pulse), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Present one sample for exactly one rising edge; returns 1ns after it.
  task automatic send_one(input logic [13:0] i, input logic [13:0] q);
    @(negedge clk);
    sample_valid = 1'b1;
    i_in = i;
    q_in = q;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [13:0] i, input logic [13:0] q, input int gap);
    for (int k = 0; k < n; k++) begin
      send_one(i, q);
      repeat (gap) @(posedge clk);
    end
    #1;
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; i_in = 14'd5000; q_in = 14'd5000;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (state_dbg !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    compared++; if (gain_sel !== 2'd0) begin mismatched++; $display("FAIL reset_gain: got %0d want 0", gain_sel); end
    compared++; if ({invert, locked, loss_pulse} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {invert, locked, loss_pulse}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_lock();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    compared++; if (state_dbg !== 2'd1 || gain_sel !== 2'd3) begin mismatched++; $display("FAIL lock_pullin: got state %0d gain %0d want 1/3", state_dbg, gain_sel); end
    send_n(255, 14'd9000, 14'd5000, 0);
    compared++; if (state_dbg !== 2'd1) begin mismatched++; $display("FAIL lock_early: got %0d want 1", state_dbg); end
    send_one(14'd9000, 14'd5000);
    @(negedge clk);
    compared++; if (state_dbg !== 2'd1) begin mismatched++; $display("FAIL lock_latency: got %0d want 1", state_dbg); end
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd2 || gain_sel !== 2'd2) begin mismatched++; $display("FAIL lock_settle: got state %0d gain %0d want 2/2", state_dbg, gain_sel); end
    send_n(511, 14'd9000, 14'd5000, 0);
    compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("FAIL lock_settle_hold: got %0d want 2", state_dbg); end
    send_one(14'd9000, 14'd5000);
    @(negedge clk);
    compared++; if (locked !== 1'b0) begin mismatched++; $display("FAIL lock_track_early: got locked %b want 0", locked); end
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd3 || gain_sel !== 2'd1 || locked !== 1'b1) begin mismatched++; $display("FAIL lock_track: got state %0d gain %0d locked %b want 3/1/1", state_dbg, gain_sel, locked); end
    compared++; if (invert !== 1'b0) begin mismatched++; $display("FAIL lock_invert: got %b want 0", invert); end
  endtask

  task automatic test_loss();
    send_n(127, 14'd7000, 14'd7000, 0);
    compared++; if (state_dbg !== 2'd3 || loss_pulse !== 1'b0) begin mismatched++; $display("FAIL loss_early: got state %0d pulse %b want 3/0", state_dbg, loss_pulse); end
    send_one(14'd7000, 14'd7000);
    @(negedge clk);
    compared++; if (loss_pulse !== 1'b0) begin mismatched++; $display("FAIL loss_latency: got pulse %b want 0", loss_pulse); end
    @(posedge clk); #1;
    compared++; if (loss_pulse !== 1'b1) begin mismatched++; $display("FAIL loss_pulse: got %b want 1", loss_pulse); end
    compared++; if (gain_sel !== 2'd3 || locked !== 1'b0 || state_dbg !== 2'd1) begin mismatched++; $display("FAIL loss_state: got gain %0d locked %b state %0d want 3/0/1", gain_sel, locked, state_dbg); end
    @(posedge clk); #1;
    compared++; if (loss_pulse !== 1'b0) begin mismatched++; $display("FAIL loss_width: got %b want 0", loss_pulse); end
    // Negative-majority window in PULL_IN must not touch invert.
    send_n(64, 14'd1000, 14'd5000, 0);
    @(posedge clk); #1;
    compared++; if (invert !== 1'b0 || state_dbg !== 2'd1) begin mismatched++; $display("FAIL invert_held: got invert %b state %0d want 0/1", invert, state_dbg); end
  endtask

  task automatic test_enable_drop();
    restart();
    send_n(256, 14'd9000, 14'd5000, 0);
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("FAIL drop_settle: got %0d want 2", state_dbg); end
    send_n(100, 14'd9000, 14'd5000, 0);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd0 || gain_sel !== 2'd0) begin mismatched++; $display("FAIL drop_idle: got state %0d gain %0d want 0/0", state_dbg, gain_sel); end
    restart();
    send_n(255, 14'd9000, 14'd5000, 0);
    compared++; if (state_dbg !== 2'd1) begin mismatched++; $display("FAIL drop_realign_early: got %0d want 1", state_dbg); end
    send_one(14'd9000, 14'd5000);
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("FAIL drop_realign_settle: got %0d want 2", state_dbg); end
  endtask

  task automatic test_neg_polarity();
    restart();
    send_n(256, 14'd1000, 14'd5000, 0);
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd2 || invert !== 1'b0) begin mismatched++; $display("FAIL neg_settle: got state %0d invert %b want 2/0", state_dbg, invert); end
    send_n(512, 14'd1000, 14'd5000, 0);
    @(negedge clk);
    compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("FAIL neg_latency: got %0d want 2", state_dbg); end
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd3 || invert !== 1'b1 || locked !== 1'b1) begin mismatched++; $display("FAIL neg_track: got state %0d invert %b locked %b want 3/1/1", state_dbg, invert, locked); end
  endtask

  task automatic test_reset_mid_track();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd0 || gain_sel !== 2'd0) begin mismatched++; $display("FAIL rst_track_state: got state %0d gain %0d want 0/0", state_dbg, gain_sel); end
    compared++; if (invert !== 1'b0 || locked !== 1'b0) begin mismatched++; $display("FAIL rst_track_flags: got invert %b locked %b want 0/0", invert, locked); end
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_boundary();
    restart();
    send_n(256, 14'd9000, 14'd7000, 0);
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("FAIL bnd_settle: got %0d want 2", state_dbg); end
    restart();
    send_n(255, 14'd9000, 14'd7000, 2);
    compared++; if (state_dbg !== 2'd1) begin mismatched++; $display("FAIL bnd3_early: got %0d want 1", state_dbg); end
    send_one(14'd9000, 14'd7000);
    @(negedge clk);
    compared++; if (state_dbg !== 2'd1) begin mismatched++; $display("FAIL bnd3_latency: got %0d want 1", state_dbg); end
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("FAIL bnd3_settle: got %0d want 2", state_dbg); end
    send_n(511, 14'd9000, 14'd7000, 2);
    compared++; if (state_dbg !== 2'd2) begin mismatched++; $display("FAIL bnd3_settle_hold: got %0d want 2", state_dbg); end
    send_one(14'd9000, 14'd7000);
    @(posedge clk); #1;
    compared++; if (state_dbg !== 2'd3 || locked !== 1'b1 || invert !== 1'b0) begin mismatched++; $display("FAIL bnd3_track: got state %0d locked %b invert %b want 3/1/0", state_dbg, locked, invert); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_loss();
    test_enable_drop();
    test_neg_polarity();
    test_reset_mid_track();
    test_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
